// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package rr_arb_pkg;

    localparam int unsigned DEFAULT_N        = 4;
    localparam int unsigned DEFAULT_MAX_HOLD = 8;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    // A one-hot input has a single set bit, so OR-ing the indices of set bits yields its position.
    function automatic int unsigned onehot2bin(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_ring_arbiter_if.sv
// Request/grant bundle between requesters (master) and the ring arbiter (slave).
interface rr_ring_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic          in_en;
    logic [N-1:0]  in_req;
    logic [N-1:0]  o_gnt;
    logic          o_gnt_valid;
    logic [IW-1:0] o_gnt_id;
    logic [N-1:0]  o_ptr;
    logic [CW-1:0] o_hold_cnt;

    modport master (
        output in_en, in_req,
        input  o_gnt, o_gnt_valid, o_gnt_id, o_ptr, o_hold_cnt
    );

    modport slave (
        input  in_en, in_req,
        output o_gnt, o_gnt_valid, o_gnt_id, o_ptr, o_hold_cnt
    );

endinterface

// File: rtl/rr_ring_arbiter_ptr_ring.sv
// One-hot priority token register; on load it takes the position just above the outgoing holder.
module rr_ptr_ring #(
    parameter int unsigned N = 4
) (
    input  logic         in_clk,
    input  logic         in_rst_n,
    input  logic         in_load,
    input  logic [N-1:0] in_holder,
    output logic [N-1:0] o_ptr
);

    logic [N-1:0] ptr_d;
    logic [N-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (in_load) ptr_d = {in_holder[N-2:0], in_holder[N-1]};
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) ptr_q <= N'(1);
        else           ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with rotating one-hot token and per-tenure hold cap.
module rr_ring_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned N        = DEFAULT_N,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    rr_ring_arbiter_if.slave  bus
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    state_e        state_d, state_q;
    logic [N-1:0]  gnt_d, gnt_q;
    logic          valid_d, valid_q;
    logic [CW-1:0] hold_d, hold_q;
    logic [N-1:0]  ptr_q;
    logic [N-1:0]  rot_ptr;
    logic          ptr_load;
    logic          tenure_end;
    logic          any_req;

    function automatic logic [N-1:0] pick(input logic [N-1:0] req, input logic [N-1:0] ptr);
        logic [N-1:0] win;
        logic         found;
        int unsigned  p;
        int unsigned  idx;
        win   = '0;
        found = 1'b0;
        p     = onehot2bin(32'(ptr));
        for (int unsigned off = 0; off < N; off++) begin
            idx = (p + off) % N;
            if (!found && req[IW'(idx)]) begin
                win[IW'(idx)] = 1'b1;
                found         = 1'b1;
            end
        end
        return win;
    endfunction

    rr_ptr_ring #(.N(N)) u_ptr_ring (
        .in_clk    (in_clk),
        .in_rst_n  (in_rst_n),
        .in_load   (ptr_load),
        .in_holder (gnt_q),
        .o_ptr     (ptr_q)
    );

    assign any_req    = |bus.in_req;
    assign rot_ptr    = {gnt_q[N-2:0], gnt_q[N-1]};
    assign tenure_end = !(|(bus.in_req & gnt_q)) || (hold_q == CW'(MAX_HOLD - 1));

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        hold_d   = hold_q;
        ptr_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_en && any_req) begin
                    state_d = GRANT;
                    gnt_d   = pick(bus.in_req, ptr_q);
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (tenure_end) begin
                    ptr_load = 1'b1;
                    hold_d   = '0;
                    // Successor is picked against the rotated token so an expiring holder ranks last.
                    if (bus.in_en && any_req) begin
                        gnt_d = pick(bus.in_req, rot_ptr);
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                hold_d  = '0;
            end
        endcase
        valid_d = |gnt_d;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.o_gnt       = gnt_q;
    assign bus.o_gnt_valid = valid_q;
    assign bus.o_gnt_id    = IW'(onehot2bin(32'(gnt_q)));
    assign bus.o_ptr       = ptr_q;
    assign bus.o_hold_cnt  = hold_q;

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed bench for rr_ring_arbiter with a per-cycle behavioural reference model.
module tb_rr_ring_arbiter;
    import rr_arb_pkg::*;

    localparam int N  = 4;
    localparam int MH = 8;

    logic clk = 1'b0;
    logic rst_n;

    rr_ring_arbiter_if #(.N(N), .MAX_HOLD(MH)) bus ();

    rr_ring_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: holder index (-1 idle), token index, cycles into tenure.
    int m_holder = -1;
    int m_ptr    = 0;
    int m_hold   = 0;

    function automatic int mpick(input logic [3:0] req, input int p);
        for (int off = 0; off < N; off++) begin
            if (req[(p + off) % N]) return (p + off) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder = -1;
            m_ptr    = 0;
            m_hold   = 0;
        end else if (m_holder < 0) begin
            if (bus.in_en && bus.in_req != 0) begin
                m_holder = mpick(bus.in_req, m_ptr);
                m_hold   = 0;
            end
        end else if (!bus.in_req[m_holder] || m_hold == MH - 1) begin
            m_ptr  = (m_holder + 1) % N;
            m_hold = 0;
            if (bus.in_en && bus.in_req != 0) m_holder = mpick(bus.in_req, m_ptr);
            else                              m_holder = -1;
        end else begin
            m_hold = m_hold + 1;
        end
    end

    always @(negedge clk) begin
        check("model_gnt",   32'(bus.o_gnt),       (m_holder < 0) ? 32'd0 : (32'd1 << m_holder));
        check("model_valid", 32'(bus.o_gnt_valid), (m_holder < 0) ? 32'd0 : 32'd1);
        check("model_id",    32'(bus.o_gnt_id),    (m_holder < 0) ? 32'd0 : 32'(m_holder));
        check("model_ptr",   32'(bus.o_ptr),       32'd1 << m_ptr);
        check("model_hold",  32'(bus.o_hold_cnt),  32'(m_hold));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_req = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [3:0] t3_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] t3_ptr [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] t3_req [9] = '{4'b1111, 4'b1110, 4'b1111, 4'b1101, 4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b0000};

    initial begin
        rst_n      = 1'b0;
        bus.in_en  = 1'b0;
        bus.in_req = '0;
        step();
        step();
        check("rst_gnt",   32'(bus.o_gnt),       32'd0);
        check("rst_valid", 32'(bus.o_gnt_valid), 32'd0);
        check("rst_id",    32'(bus.o_gnt_id),    32'd0);
        check("rst_ptr",   32'(bus.o_ptr),       32'd1);
        check("rst_hold",  32'(bus.o_hold_cnt),  32'd0);
        rst_n     = 1'b1;
        bus.in_en = 1'b1;

        // No requests: idle, token parked at bit 0.
        repeat (10) begin
            step();
            check("idle_gnt",  32'(bus.o_gnt),      32'd0);
            check("idle_ptr",  32'(bus.o_ptr),      32'd1);
            check("idle_hold", 32'(bus.o_hold_cnt), 32'd0);
        end

        // Two contenders, expiry-driven rotation.
        bus.in_req = 4'b1010;
        step();
        check("t2_first_gnt",  32'(bus.o_gnt),      32'b0010);
        check("t2_first_id",   32'(bus.o_gnt_id),   32'd1);
        check("t2_first_hold", 32'(bus.o_hold_cnt), 32'd0);
        repeat (7) step();
        check("t2_hold_max",   32'(bus.o_hold_cnt), 32'd7);
        check("t2_hold_gnt",   32'(bus.o_gnt),      32'b0010);
        step();
        check("t2_swap_gnt",   32'(bus.o_gnt),      32'b1000);
        check("t2_swap_ptr",   32'(bus.o_ptr),      32'b0100);
        check("t2_swap_valid", 32'(bus.o_gnt_valid), 32'd1);
        check("t2_swap_hold",  32'(bus.o_hold_cnt), 32'd0);
        repeat (8) step();
        check("t2_back_gnt",   32'(bus.o_gnt),      32'b0010);
        check("t2_back_ptr",   32'(bus.o_ptr),      32'b0001);
        bus.in_req = '0;
        step();
        check("t2_rel_gnt",    32'(bus.o_gnt),      32'd0);
        check("t2_rel_ptr",    32'(bus.o_ptr),      32'b0100);
        do_reset();

        // All request, each drops one cycle after grant.
        bus.in_req = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            step();
            check("t3_gnt", 32'(bus.o_gnt), 32'(t3_gnt[i]));
            check("t3_ptr", 32'(bus.o_ptr), 32'(t3_ptr[i]));
            bus.in_req = t3_req[i];
        end
        do_reset();

        // Single persistent requester re-granted on expiry.
        bus.in_req = 4'b0001;
        repeat (8) step();
        check("t4_hold7",  32'(bus.o_hold_cnt), 32'd7);
        check("t4_ptr0",   32'(bus.o_ptr),      32'b0001);
        step();
        check("t4_wrap",   32'(bus.o_hold_cnt), 32'd0);
        check("t4_regnt",  32'(bus.o_gnt),      32'b0001);
        check("t4_ptr1",   32'(bus.o_ptr),      32'b0010);
        repeat (11) step();
        check("t4_end_hold", 32'(bus.o_hold_cnt), 32'd3);
        check("t4_end_ptr",  32'(bus.o_ptr),      32'b0010);
        check("t4_end_gnt",  32'(bus.o_gnt),      32'b0001);
        bus.in_req = '0;
        step();
        do_reset();

        // Enable drops mid-tenure: no successor until re-enabled.
        bus.in_req = 4'b0100;
        step();
        check("t5_gnt2", 32'(bus.o_gnt), 32'b0100);
        bus.in_en  = 1'b0;
        bus.in_req = 4'b0110;
        repeat (3) step();
        check("t5_keep_gnt",  32'(bus.o_gnt),      32'b0100);
        check("t5_keep_hold", 32'(bus.o_hold_cnt), 32'd3);
        bus.in_req = 4'b0010;
        step();
        check("t5_idle_gnt",   32'(bus.o_gnt),       32'd0);
        check("t5_idle_valid", 32'(bus.o_gnt_valid), 32'd0);
        check("t5_idle_ptr",   32'(bus.o_ptr),       32'b1000);
        step();
        check("t5_still_idle", 32'(bus.o_gnt), 32'd0);
        bus.in_en = 1'b1;
        step();
        check("t5_reen_gnt", 32'(bus.o_gnt),    32'b0010);
        check("t5_reen_id",  32'(bus.o_gnt_id), 32'd1);
        bus.in_req = '0;
        step();
        do_reset();

        // Asynchronous reset mid-tenure.
        bus.in_req = 4'b0010;
        repeat (4) step();
        check("t6_pre_hold", 32'(bus.o_hold_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_gnt",   32'(bus.o_gnt),       32'd0);
        check("t6_async_valid", 32'(bus.o_gnt_valid), 32'd0);
        check("t6_async_ptr",   32'(bus.o_ptr),       32'b0001);
        check("t6_async_hold",  32'(bus.o_hold_cnt),  32'd0);
        bus.in_req = 4'b0100;
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_gnt", 32'(bus.o_gnt),    32'b0100);
        check("t6_post_id",  32'(bus.o_gnt_id), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
